prio_rr_arbiter_sync: RTL and testbench

//  Clocked N-source priority arbiter with grant hold and round-robin tie-break.

---
 rtl/prio_rr_arbiter_sync.sv | 141 ++++++++++++++
 tb/tb_prio_rr_arbiter_sync.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_rr_arbiter_sync.sv
// N-source priority arbiter: the lowest priority value wins, ties rotate round-robin,
// and the registered grant is held until done, request drop or hold-limit expiry.
module prio_rr_arbiter_sync #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int MAX_HOLD  = 0,
  localparam int SEL_W    = $clog2(N)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N-1:0]           req_i,
  input  logic [N*PRIO_BITS-1:0] prio_i,
  input  logic                   done_i,
  output logic [N-1:0]           gnt_o,
  output logic                   gnt_valid_o,
  output logic [SEL_W-1:0]       sel_o,
  output logic [PRIO_BITS-1:0]   prio_o
);

  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_LAST_I);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [N-1:0]           r_gnt, w_gnt_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [SEL_W-1:0]       r_sel, w_sel_nxt;
  logic [PRIO_BITS-1:0]   r_prio, w_prio_nxt;
  logic [SEL_W-1:0]       r_rr, w_rr_nxt;
  logic [HC_W-1:0]        r_hold, w_hold_nxt;

  logic [PRIO_BITS-1:0]   w_prio [N];
  logic [SEL_W:0]         w_ext;
  logic [SEL_W-1:0]       w_idx;
  logic [SEL_W-1:0]       w_win;
  logic [PRIO_BITS-1:0]   w_best;
  logic                   w_hit;
  logic                   w_any_req;
  logic                   w_release;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_prio[k] = prio_i[k*PRIO_BITS +: PRIO_BITS];
  end

  // Scan starts just after the last grantee; strict '<' keeps the first tied index.
  always_comb begin
    w_win  = '0;
    w_best = '0;
    w_hit  = 1'b0;
    w_ext  = '0;
    w_idx  = '0;
    for (int k = 0; k < N; k++) begin
      w_ext = {1'b0, r_rr} + (SEL_W+1)'(k + 1);
      if (w_ext >= (SEL_W+1)'(N)) w_ext = w_ext - (SEL_W+1)'(N);
      w_idx = w_ext[SEL_W-1:0];
      if (req_i[w_idx] && (!w_hit || (w_prio[w_idx] < w_best))) begin
        w_hit  = 1'b1;
        w_best = w_prio[w_idx];
        w_win  = w_idx;
      end
    end
  end

  assign w_any_req = |req_i;
  assign w_release = done_i || !req_i[r_sel] ||
                     ((MAX_HOLD != 0) && (r_hold == HOLD_LAST));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_prio  <= '0;
      r_rr    <= SEL_W'(N - 1);
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
      r_sel   <= w_sel_nxt;
      r_prio  <= w_prio_nxt;
      r_rr    <= w_rr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_GRANT;
      S_GRANT: if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;
    w_sel_nxt   = r_sel;
    w_prio_nxt  = r_prio;
    w_rr_nxt    = r_rr;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_sel_nxt   = '0;
        w_prio_nxt  = '0;
        w_hold_nxt  = '0;
        if (w_any_req) begin
          w_gnt_nxt[w_win] = 1'b1;
          w_valid_nxt      = 1'b1;
          w_sel_nxt        = w_win;
          w_prio_nxt       = w_prio[w_win];
          w_rr_nxt         = w_win;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_sel_nxt   = '0;
          w_prio_nxt  = '0;
          w_hold_nxt  = '0;
        end else if (r_hold != '1) begin
          w_hold_nxt = r_hold + HC_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = r_valid;
  assign sel_o       = r_sel;
  assign prio_o      = r_prio;

endmodule

// File: tb/tb_prio_rr_arbiter_sync.sv
// Bench for prio_rr_arbiter_sync: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a rule-level reference model on three configurations.
module tb_prio_rr_arbiter_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: N=8 unlimited hold, B: N=8 MAX_HOLD=4, C: N=5 unlimited hold
  logic [7:0]  req_a = '0, gnt_a;  logic [23:0] prio_a = '0; logic done_a = 1'b0;
  logic        vld_a;  logic [2:0] sel_a;  logic [2:0] pro_a;
  logic [7:0]  req_b = '0, gnt_b;  logic [23:0] prio_b = '0; logic done_b = 1'b0;
  logic        vld_b;  logic [2:0] sel_b;  logic [2:0] pro_b;
  logic [4:0]  req_c = '0, gnt_c;  logic [14:0] prio_c = '0; logic done_c = 1'b0;
  logic        vld_c;  logic [2:0] sel_c;  logic [2:0] pro_c;

  prio_rr_arbiter_sync #(.N(8), .PRIO_BITS(3), .MAX_HOLD(0)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .prio_i(prio_a), .done_i(done_a),
    .gnt_o(gnt_a), .gnt_valid_o(vld_a), .sel_o(sel_a), .prio_o(pro_a));
  prio_rr_arbiter_sync #(.N(8), .PRIO_BITS(3), .MAX_HOLD(4)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .prio_i(prio_b), .done_i(done_b),
    .gnt_o(gnt_b), .gnt_valid_o(vld_b), .sel_o(sel_b), .prio_o(pro_b));
  prio_rr_arbiter_sync #(.N(5), .PRIO_BITS(3), .MAX_HOLD(0)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .prio_i(prio_c), .done_i(done_c),
    .gnt_o(gnt_c), .gnt_valid_o(vld_c), .sel_o(sel_c), .prio_o(pro_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pall(input int p);
    logic [23:0] v;
    for (int k = 0; k < 8; k++) v[3*k +: 3] = 3'(p);
    return v;
  endfunction

  function automatic logic [23:0] pset(input logic [23:0] b, input int k, input int p);
    logic [23:0] v;
    v = b;
    v[3*k +: 3] = 3'(p);
    return v;
  endfunction

  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic [23:0] prio;
    logic        done;
    logic        ev;
    int          es;
    int          ep;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] q, input logic [23:0] p, input logic d,
                     input logic ev, input int es, input int ep);
    vec_t t;
    t.rst = r; t.req = q; t.prio = p; t.done = d; t.ev = ev; t.es = es; t.ep = ep;
    tbl.push_back(t);
  endtask

  // Reference model: grant owner, captured priority, last grantee, cycles held.
  int m_act[3], m_sel[3], m_pr[3], m_rr[3], m_held[3];

  task automatic model_step(input int id, input int n, input int mh, input logic [7:0] req,
                            input logic [23:0] pr, input bit dn, input bit rs);
    int best, win;
    if (rs) begin
      m_act[id] = 0; m_sel[id] = 0; m_pr[id] = 0; m_rr[id] = n - 1; m_held[id] = 0;
      return;
    end
    if (m_act[id] != 0) begin
      m_held[id]++;
      if (dn || !req[m_sel[id]] || (mh != 0 && m_held[id] >= mh)) begin
        m_act[id] = 0; m_sel[id] = 0; m_pr[id] = 0;
      end
      return;
    end
    best = 1000;
    for (int k = 0; k < n; k++)
      if (req[k] && int'(pr[3*k +: 3]) < best) best = int'(pr[3*k +: 3]);
    if (best == 1000) return;
    win = -1;
    for (int d = 1; d <= n && win < 0; d++) begin
      int k;
      k = (m_rr[id] + d) % n;
      if (req[k] && int'(pr[3*k +: 3]) == best) win = k;
    end
    m_act[id] = 1; m_sel[id] = win; m_pr[id] = best; m_rr[id] = win; m_held[id] = 0;
  endtask

  task automatic cmp_model(input int id, input int g, input int v, input int s, input int p,
                           input int cyc);
    string t;
    t = $sformatf("rand%0d_c%0d", id, cyc);
    chk({t, "_gnt"},  g, (m_act[id] != 0) ? (1 << m_sel[id]) : 0);
    chk({t, "_vld"},  v, m_act[id]);
    chk({t, "_sel"},  s, m_sel[id]);
    chk({t, "_prio"}, p, m_pr[id]);
  endtask

  initial begin
    logic [23:0] p1, p3a, p3b;
    p1  = pset(pset(pall(7), 5, 2), 7, 1);
    p3a = pset(pall(7), 2, 5);
    p3b = pset(p3a, 1, 0);

    add(1, 8'h00, pall(0), 0, 0, 0, 0);
    add(0, 8'hA0, p1,      0, 1, 7, 1);
    add(0, 8'hA0, p1,      1, 0, 0, 0);
    add(1, 8'h00, pall(0), 0, 0, 0, 0);
    add(0, 8'h29, pall(4), 0, 1, 0, 4);
    add(0, 8'h29, pall(4), 1, 0, 0, 0);
    add(0, 8'h29, pall(4), 0, 1, 3, 4);
    add(0, 8'h29, pall(4), 1, 0, 0, 0);
    add(0, 8'h29, pall(4), 0, 1, 5, 4);
    add(0, 8'h29, pall(4), 1, 0, 0, 0);
    add(0, 8'h29, pall(4), 0, 1, 0, 4);
    add(0, 8'h29, pall(4), 1, 0, 0, 0);
    add(0, 8'h04, p3a,     0, 1, 2, 5);
    add(0, 8'h06, p3b,     0, 1, 2, 5);
    add(0, 8'h06, p3b,     0, 1, 2, 5);
    add(0, 8'h06, p3b,     1, 0, 0, 0);
    add(0, 8'h06, p3b,     0, 1, 1, 0);
    add(0, 8'h06, p3b,     1, 0, 0, 0);
    add(0, 8'h40, pall(7), 0, 1, 6, 7);
    add(0, 8'h40, pall(7), 0, 1, 6, 7);
    add(0, 8'h00, pall(7), 0, 0, 0, 0);
    add(0, 8'h02, pall(3), 0, 1, 1, 3);
    add(1, 8'h06, pall(3), 0, 0, 0, 0);
    add(0, 8'h06, pall(3), 0, 1, 1, 3);
    add(0, 8'h06, pall(3), 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req_a = tbl[i].req; prio_a = tbl[i].prio; done_a = tbl[i].done;
      step();
      chk($sformatf("vec%0d_gnt", i),  int'(gnt_a), tbl[i].ev ? (1 << tbl[i].es) : 0);
      chk($sformatf("vec%0d_vld", i),  int'(vld_a), int'(tbl[i].ev));
      chk($sformatf("vec%0d_sel", i),  int'(sel_a), tbl[i].es);
      chk($sformatf("vec%0d_prio", i), int'(pro_a), tbl[i].ep);
    end
    req_a = '0; done_a = 1'b0;

    // Hold limit of 4: four granted cycles, one idle, then regrant of the same source.
    rst = 1'b1; step(); rst = 1'b0;
    req_b = 8'h01; prio_b = pall(2);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("hold_c%0d_vld", c), int'(vld_b), (c == 4) ? 0 : 1);
      chk($sformatf("hold_c%0d_gnt", c), int'(gnt_b), (c == 4) ? 0 : 1);
    end
    req_b = '0;

    // N=5 wrap: last grantee 2, then equal-priority 0,3,4 rotate 3,4,0.
    rst = 1'b1; step(); rst = 1'b0;
    req_c = 5'b00100; prio_c = 15'h0000;
    step(); chk("n5_first_sel", int'(sel_c), 2); chk("n5_first_vld", int'(vld_c), 1);
    done_c = 1'b1; step(); chk("n5_rel0", int'(vld_c), 0);
    done_c = 1'b0; req_c = 5'b11001; prio_c = 15'h2492;
    step(); chk("n5_g3_sel", int'(sel_c), 3); chk("n5_g3_gnt", int'(gnt_c), 8);
    done_c = 1'b1; step(); chk("n5_rel1", int'(vld_c), 0);
    done_c = 1'b0; step(); chk("n5_g4_sel", int'(sel_c), 4); chk("n5_g4_gnt", int'(gnt_c), 16);
    done_c = 1'b1; step(); chk("n5_rel2", int'(vld_c), 0);
    done_c = 1'b0; step(); chk("n5_g0_sel", int'(sel_c), 0); chk("n5_g0_gnt", int'(gnt_c), 1);
    req_c = '0;

    // Randomized traffic on all three instances against the reference model.
    rst = 1'b1;
    model_step(0, 8, 0, 8'h0, 24'h0, 1'b0, 1'b1);
    model_step(1, 8, 4, 8'h0, 24'h0, 1'b0, 1'b1);
    model_step(2, 5, 0, 8'h0, 24'h0, 1'b0, 1'b1);
    step();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req_a = 8'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) req_b = 8'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) req_c = 5'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < 8; k++) prio_a[3*k +: 3] = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < 8; k++) prio_b[3*k +: 3] = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < 5; k++) prio_c[3*k +: 3] = 3'($urandom_range(0, 3));
      done_a = ($urandom_range(0, 4) == 0);
      done_b = ($urandom_range(0, 6) == 0);
      done_c = ($urandom_range(0, 4) == 0);
      model_step(0, 8, 0, req_a, prio_a, done_a, rst);
      model_step(1, 8, 4, req_b, prio_b, done_b, rst);
      model_step(2, 5, 0, {3'b000, req_c}, {9'h000, prio_c}, done_c, rst);
      step();
      cmp_model(0, int'(gnt_a), int'(vld_a), int'(sel_a), int'(pro_a), c);
      cmp_model(1, int'(gnt_b), int'(vld_b), int'(sel_b), int'(pro_b), c);
      cmp_model(2, int'(gnt_c), int'(vld_c), int'(sel_c), int'(pro_c), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
